sram_access_ctrl: RTL and testbench

Single-port access sequencer for the SRAM macro. It accepts read/write requests over a valid/ready handshake and drives the row control decoder's `addr`/`enable` inputs. It also sequences bitline precharge, write drivers and sense-amp enable through fixed, parameterised phase counts. It sits between the tile's host-side register logic and the array (decoder, write drivers, sense amps).

---
 rtl/sram_access_ctrl.sv | 110 +++++++++++
 tb/tb_sram_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access sequencer: valid/ready request in, phased precharge/wordline/sense control out.
// Optional SRAM_CTRL_BACK2BACK_EN lets a new request be accepted in DONE for back-to-back accesses.
module sram_access_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [2:0]        dec_addr,
    output logic              dec_enable,
    output logic              precharge,
    output logic              write_en,
    output logic              sense_en,
    output logic [DATA_W-1:0] wdata_out,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PRE    = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       lat_we;
    logic       accept;

`ifdef SRAM_CTRL_BACK2BACK_EN
    assign req_ready = (state == IDLE) || (state == DONE);
`else
    assign req_ready = (state == IDLE);
`endif

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            dec_addr  <= '0;
            wdata_out <= '0;
            rsp_rdata <= '0;
        end else begin
            // Address and write data only move on acceptance, so the decoder sees a settled address through PRE.
            if (accept) begin
                lat_we    <= req_we;
                dec_addr  <= req_addr;
                wdata_out <= req_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= PRE;
                        cnt   <= PRE_LOAD;
                    end
                end
                PRE: begin
                    if (cnt == 4'd0) begin
                        state <= ACCESS;
                        cnt   <= WL_LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        if (!lat_we) begin
                            rsp_rdata <= sram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state <= PRE;
                        cnt   <= PRE_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign precharge  = (state == PRE);
    assign dec_enable = (state == ACCESS);
    assign write_en   = (state == ACCESS) && lat_we;
    assign sense_en   = (state == ACCESS) && !lat_we && (cnt == 4'd0);
    assign rsp_valid  = (state == DONE);
    assign rsp_we     = (state == DONE) && lat_we;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: default instance plus a PRE_CYCLES=3/WL_CYCLES=1 instance.
module tb_sram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] v;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] sram_rdata;

    logic [1:0]      rdy, rv, rwe, busy, den, pre, wen, sen;
    logic [1:0][7:0] rdata, wdo;
    logic [1:0][2:0] daddr;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int sel      = 0;
    logic [1:0][7:0] mdl_rdata;

`ifdef SRAM_CTRL_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    sram_access_ctrl #(.DATA_W(8), .PRE_CYCLES(1), .WL_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_we(rwe[0]),
        .rsp_rdata(rdata[0]), .busy(busy[0]), .dec_addr(daddr[0]), .dec_enable(den[0]),
        .precharge(pre[0]), .write_en(wen[0]), .sense_en(sen[0]), .wdata_out(wdo[0]),
        .sram_rdata(sram_rdata)
    );

    sram_access_ctrl #(.DATA_W(8), .PRE_CYCLES(3), .WL_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_we(rwe[1]),
        .rsp_rdata(rdata[1]), .busy(busy[1]), .dec_addr(daddr[1]), .dec_enable(den[1]),
        .precharge(pre[1]), .write_en(wen[1]), .sense_en(sen[1]), .wdata_out(wdo[1]),
        .sram_rdata(sram_rdata)
    );

    function automatic int pcyc(int s);
        return (s != 0) ? 3 : 1;
    endfunction

    function automatic int wcyc(int s);
        return (s != 0) ? 1 : 2;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!rdy[sel] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy[sel]) begin
            chk_cnt++;
            $display("FAIL wait_ready dut%0d: req_ready=%0b after %0d cycles, required 1", sel, rdy[sel], n);
        end
    endtask

    // One full access on instance 'sel', checked cycle by cycle from the acceptance edge.
    task automatic access(input bit we, input logic [2:0] a, input logic [7:0] d, input logic [7:0] rd);
        int p = pcyc(sel);
        int w = wcyc(sel);
        logic [7:0] exp_v, obs_v;
        wait_ready();
        v[sel]     = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        sram_rdata = 8'($urandom);
        @(posedge clk); #1;
        v[sel]    = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 3'($urandom);
        req_wdata = 8'($urandom);
        for (int k = 1; k <= p + w + 1; k++) begin
            if (k == p + w + 1 && !we) mdl_rdata[sel] = rd;
            exp_v = {(B2B && k == p + w + 1), 1'b1, (k <= p), (k > p && k <= p + w),
                     (we && k > p && k <= p + w), (!we && k == p + w), (k == p + w + 1),
                     (we && k == p + w + 1)};
            obs_v = {rdy[sel], busy[sel], pre[sel], den[sel], wen[sel], sen[sel], rv[sel],
                     rwe[sel] & rv[sel]};
            chk_cnt++;
            if (obs_v !== exp_v)
                $display("FAIL ctrl dut%0d cycle %0d: {rdy,busy,pre,en,we,se,rv,rwe}=%b required %b", sel, k, obs_v, exp_v);
            else pass_cnt++;
            chk_cnt++;
            if (daddr[sel] !== a || wdo[sel] !== d)
                $display("FAIL addr_data dut%0d cycle %0d: dec_addr=%0d wdata_out=%h required %0d %h", sel, k, daddr[sel], wdo[sel], a, d);
            else pass_cnt++;
            chk_cnt++;
            if (rdata[sel] !== mdl_rdata[sel])
                $display("FAIL rsp_rdata dut%0d cycle %0d: %h required %h", sel, k, rdata[sel], mdl_rdata[sel]);
            else pass_cnt++;
            sram_rdata = (k == p + w) ? rd : 8'($urandom);
            if (k < p + w + 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk_cnt++;
            if ({rdy[s], busy[s], pre[s], den[s], wen[s], sen[s], rv[s], rwe[s]} !== 8'b1000_0000 ||
                rdata[s] !== 8'h00 || daddr[s] !== 3'd0 || wdo[s] !== 8'h00)
                $display("FAIL %s dut%0d: ctrl=%b rdata=%h dec_addr=%0d wdata_out=%h required ctrl=10000000 and zeros",
                         tag, s, {rdy[s], busy[s], pre[s], den[s], wen[s], sen[s], rv[s], rwe[s]},
                         rdata[s], daddr[s], wdo[s]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sram_rdata = '0;
        mdl_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_write();
        sel = 0;
        access(1'b1, 3'd5, 8'hA5, 8'h00);
    endtask

    task automatic test_read();
        sel = 0;
        access(1'b0, 3'd3, 8'h11, 8'h3C);
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (rdata[0] !== 8'h3C) $display("FAIL read_hold: rsp_rdata=%h required 3c", rdata[0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(1, 0));
            access(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int period = B2B ? 4 : 5;
        int last = -1;
        bit pending = 1'b0;
        bit alt = 1'b0;
        logic [2:0] exp_a = '0;
        logic [7:0] exp_d = '0;
        sel = 0;
        wait_ready();
        v[0] = 1'b1;
        req_we = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (pending) begin
                chk_cnt++;
                if (daddr[0] !== exp_a || wdo[0] !== exp_d)
                    $display("FAIL b2b_addr cycle %0d: dec_addr=%0d wdata_out=%h required %0d %h", c, daddr[0], wdo[0], exp_a, exp_d);
                else pass_cnt++;
                pending = 1'b0;
            end
            if (rdy[0]) begin
                if (last >= 0) begin
                    chk_cnt++;
                    if (c - last !== period)
                        $display("FAIL b2b_period: accept spacing %0d cycles required %0d", c - last, period);
                    else pass_cnt++;
                end
                last = c;
                exp_a = alt ? 3'd2 : 3'd1;
                exp_d = 8'($urandom);
                alt = !alt;
                req_addr = exp_a;
                req_wdata = exp_d;
                pending = 1'b1;
            end else begin
                req_addr = 3'($urandom);
                req_wdata = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        v[0] = 1'b0;
        for (int n = 0; n < 20 && busy[0]; n++) begin
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (busy[0] !== 1'b0 || rdata[0] !== mdl_rdata[0])
            $display("FAIL b2b_drain: busy=%0b rsp_rdata=%h required 0 %h", busy[0], rdata[0], mdl_rdata[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        sel = 0;
        wait_ready();
        v[0] = 1'b1; req_we = 1'b1; req_addr = 3'd6; req_wdata = 8'h5A;
        @(posedge clk); #1;
        v[0] = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if ({den[0], wen[0]} !== 2'b11) $display("FAIL mid_access_pre: {en,we}=%b required 11", {den[0], wen[0]});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({den[0], wen[0], busy[0], rv[0], rdy[0]} !== 5'b00001)
            $display("FAIL mid_access_reset: {en,we,busy,rv,rdy}=%b required 00001", {den[0], wen[0], busy[0], rv[0], rdy[0]});
        else pass_cnt++;
        mdl_rdata = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (rv[0] !== 1'b0 || busy[0] !== 1'b0)
                $display("FAIL no_rsp_after_reset cycle %0d: rsp_valid=%0b busy=%0b required 0 0", c, rv[0], busy[0]);
            else pass_cnt++;
        end
        check_idle_outputs("after_mid_reset");
        access(1'b0, 3'd4, 8'h00, 8'hC3);
    endtask

    task automatic test_long_pre();
        sel = 1;
        access(1'b0, 3'd7, 8'h00, 8'h96);
        access(1'b1, 3'd2, 8'h4B, 8'h00);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        test_long_pre();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
